// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the memory-slave state type.
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam int unsigned WCNT_W = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2} state_t;
endpackage

// File: rtl/ahb_byte_strobe.sv
// Little-endian byte-lane strobe and alignment check for a 32-bit AHB lane.
module ahb_byte_strobe
  import ahb_pkg::*;
(
  input  logic [2:0] size,
  input  logic [1:0] addr,
  output logic [3:0] strb,
  output logic       misalign
);
  always_comb begin
    strb     = '0;
    misalign = 1'b0;
    case (size)
      HSIZE_BYTE: strb = 4'b0001 << addr;
      HSIZE_HALF: begin
        strb     = addr[1] ? 4'b1100 : 4'b0011;
        misalign = addr[0];
      end
      HSIZE_WORD: begin
        strb     = '1;
        misalign = |addr;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/ahb_mem_slave.sv
// AHB-Lite word-organised memory slave with programmable wait states and
// two-cycle ERROR response for out-of-range, oversized or misaligned accesses.
module ahb_mem_slave
  import ahb_pkg::*;
#(
  parameter int unsigned ADDRW       = 32,
  parameter int unsigned DATAW       = 32,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             HSEL,
  input  logic [ADDRW-1:0] HADDR,
  input  logic [DATAW-1:0] HWDATA,
  input  logic             HWRITE,
  input  logic [2:0]       HSIZE,
  input  logic [2:0]       HBURST,
  input  logic [3:0]       HPROT,
  input  logic [1:0]       HTRANS,
  input  logic             HREADY,
  output logic             HREADYOUT,
  output logic [DATAW-1:0] HRDATA,
  output logic             HRESP
);
  localparam int unsigned       IDXW      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDRW:0]    MEM_BYTES = (ADDRW+1)'(MEM_DEPTH * 4);
  localparam logic [WCNT_W-1:0] WAIT_INIT = WCNT_W'(WAIT_STATES);

  logic [DATAW-1:0]  mem [MEM_DEPTH];
  state_t            state;
  logic [WCNT_W-1:0] wcnt;
  logic [IDXW+1:0]   ph_addr;
  logic              ph_write;
  logic [2:0]        ph_size;
  logic [DATAW-1:0]  rdata;
  logic              ready_q;
  logic              resp_q;

  logic [3:0]        a_strb_unused;
  logic              a_misalign;
  logic [3:0]        w_strb;
  logic              w_misalign_unused;
  logic              accept, take, completing, a_err, do_write;
  logic [IDXW-1:0]   ridx, widx;
  logic [DATAW-1:0]  rd_word;
  logic              unused_inputs;

  ahb_byte_strobe u_addr_strobe (
    .size     (HSIZE),
    .addr     (HADDR[1:0]),
    .strb     (a_strb_unused),
    .misalign (a_misalign)
  );

  ahb_byte_strobe u_data_strobe (
    .size     (ph_size),
    .addr     (ph_addr[1:0]),
    .strb     (w_strb),
    .misalign (w_misalign_unused)
  );

  assign unused_inputs = ^{HBURST, HPROT};

  assign accept     = HSEL && HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
  assign completing = (state == ST_DATA) && (wcnt == '0);
  assign take       = accept && (state == ST_IDLE || state == ST_ERR2 || completing);
  assign a_err      = ({1'b0, HADDR} >= MEM_BYTES) || (HSIZE > HSIZE_WORD) || a_misalign;
  assign do_write   = completing && ph_write;
  assign ridx       = HADDR[IDXW+1:2];
  assign widx       = ph_addr[IDXW+1:2];

  // Read of a word being written at the same edge sees the new bytes.
  always_comb begin
    rd_word = mem[ridx];
    if (do_write && widx == ridx) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (w_strb[b]) rd_word[8*b +: 8] = HWDATA[8*b +: 8];
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESET && do_write) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (w_strb[b]) mem[widx][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  // HREADYOUT/HRESP are registered from the next-state decision.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state    <= ST_IDLE;
      wcnt     <= '0;
      ph_addr  <= '0;
      ph_write <= 1'b0;
      ph_size  <= '0;
      rdata    <= '0;
      ready_q  <= 1'b1;
      resp_q   <= HRESP_OKAY;
    end else if (take) begin
      ph_addr  <= HADDR[IDXW+1:0];
      ph_write <= HWRITE;
      ph_size  <= HSIZE;
      if (a_err) begin
        state   <= ST_ERR1;
        ready_q <= 1'b0;
        resp_q  <= HRESP_ERROR;
      end else begin
        state   <= ST_DATA;
        wcnt    <= WAIT_INIT;
        ready_q <= (WAIT_STATES == 0);
        resp_q  <= HRESP_OKAY;
        if (!HWRITE) rdata <= rd_word;
      end
    end else begin
      case (state)
        ST_DATA: begin
          if (wcnt != '0) begin
            wcnt    <= wcnt - 1'b1;
            ready_q <= (wcnt == 1);
          end else begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
            resp_q  <= HRESP_OKAY;
          end
        end
        ST_ERR1: begin
          state   <= ST_ERR2;
          ready_q <= 1'b1;
          resp_q  <= HRESP_ERROR;
        end
        ST_ERR2: begin
          state   <= ST_IDLE;
          ready_q <= 1'b1;
          resp_q  <= HRESP_OKAY;
        end
        default: begin
          state   <= ST_IDLE;
          ready_q <= 1'b1;
          resp_q  <= HRESP_OKAY;
        end
      endcase
    end
  end

  assign HREADYOUT = ready_q;
  assign HRESP     = resp_q;
  assign HRDATA    = rdata;
endmodule

// File: tb/tb_ahb_mem_slave.sv
// Scoreboard bench for ahb_mem_slave: three instances (0, 2, 3 wait states) on one muxed bus.
module tb_ahb_mem_slave;
  import ahb_pkg::*;

  typedef struct {
    int          id;
    logic [31:0] data;
    logic        resp;
    int unsigned waits;
  } exp_t;

  logic        HCLK;
  logic        HRESET, HSEL, HWRITE;
  logic [31:0] HADDR, HWDATA;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  int unsigned dsel;

  logic [2:0]  ro, rs;
  logic [31:0] rd [3];
  logic        bus_ready, bus_resp;
  logic [31:0] bus_rdata;

  exp_t        exp_q [$];
  logic [31:0] last_rd [3];
  int          id_ctr;
  int          n_cmp, n_bad;

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  ahb_mem_slave #(.ADDRW(32), .DATAW(32), .MEM_DEPTH(256), .WAIT_STATES(0)) u_ws0 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL && dsel == 0), .HADDR(HADDR), .HWDATA(HWDATA),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
    .HREADY(bus_ready), .HREADYOUT(ro[0]), .HRDATA(rd[0]), .HRESP(rs[0]));

  ahb_mem_slave #(.ADDRW(32), .DATAW(32), .MEM_DEPTH(256), .WAIT_STATES(2)) u_ws2 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL && dsel == 1), .HADDR(HADDR), .HWDATA(HWDATA),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
    .HREADY(bus_ready), .HREADYOUT(ro[1]), .HRDATA(rd[1]), .HRESP(rs[1]));

  ahb_mem_slave #(.ADDRW(32), .DATAW(32), .MEM_DEPTH(256), .WAIT_STATES(3)) u_ws3 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL && dsel == 2), .HADDR(HADDR), .HWDATA(HWDATA),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
    .HREADY(bus_ready), .HREADYOUT(ro[2]), .HRDATA(rd[2]), .HRESP(rs[2]));

  always_comb begin
    bus_ready = ro[0];
    bus_resp  = rs[0];
    bus_rdata = rd[0];
    case (dsel)
      1: begin bus_ready = ro[1]; bus_resp = rs[1]; bus_rdata = rd[1]; end
      2: begin bus_ready = ro[2]; bus_resp = rs[2]; bus_rdata = rd[2]; end
      default: ;
    endcase
  end

  function automatic int unsigned ws_of(input int unsigned d);
    case (d)
      1: return 2;
      2: return 3;
      default: return 0;
    endcase
  endfunction

  task automatic cmp(input int id, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s #%0d: got 0x%08h, want 0x%08h", nm, id, act, exp);
    end
  endtask

  // Wait for HREADY high before an edge, then step past that edge.
  task automatic wait_ready();
    bit r;
    int unsigned n;
    n = 0;
    do begin
      @(negedge HCLK);
      r = bus_ready;
      n++;
      @(posedge HCLK);
    end while (!r && n < 50);
    #1;
    if (!r) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: got HREADY=0 for %0d cycles, want 1", n);
    end
  endtask

  task automatic addr_phase(input bit wr, input logic [31:0] a, input logic [2:0] sz,
                            input logic [1:0] tr, input logic [31:0] wd,
                            input logic [31:0] rexp, input bit err);
    exp_t e;
    HSEL   = 1'b1;
    HTRANS = tr;
    HWRITE = wr;
    HADDR  = a;
    HSIZE  = sz;
    if (!err && !wr) last_rd[dsel] = rexp;
    e.id    = id_ctr++;
    e.resp  = err;
    e.waits = err ? 1 : ws_of(dsel);
    e.data  = last_rd[dsel];
    exp_q.push_back(e);
    wait_ready();
    HWDATA = wd;
  endtask

  task automatic bus_idle();
    HSEL   = 1'b0;
    HTRANS = HTRANS_IDLE;
    wait_ready();
  endtask

  // Monitor: completes a data phase whenever HREADY is seen high while one is pending.
  initial begin : monitor
    bit          pend;
    bit          resp_ok;
    int unsigned w;
    exp_t        e;
    pend = 0;
    resp_ok = 1;
    w = 0;
    forever begin
      @(negedge HCLK);
      if (HRESET) begin
        if (pend && exp_q.size() > 0) void'(exp_q.pop_front());
        pend = 0;
        continue;
      end
      if (pend) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL scoreboard_empty: got data phase, want none pending");
          pend = 0;
        end else if (!bus_ready) begin
          if (bus_resp !== exp_q[0].resp) resp_ok = 0;
          w++;
        end else begin
          e = exp_q.pop_front();
          cmp(e.id, "hresp", {31'd0, bus_resp}, {31'd0, e.resp});
          cmp(e.id, "hresp_in_wait", {31'd0, resp_ok}, 32'd1);
          cmp(e.id, "wait_cycles", w, e.waits);
          cmp(e.id, "hrdata", bus_rdata, e.data);
          pend = 0;
        end
      end
      if (HSEL && bus_ready && HTRANS[1]) begin
        pend = 1;
        w = 0;
        resp_ok = 1;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish by 200000 ns, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [31:0] bdat [4];
    bdat[0] = 32'hA000_0000; bdat[1] = 32'hA111_1111;
    bdat[2] = 32'hA222_2222; bdat[3] = 32'hA333_3333;
    n_cmp = 0; n_bad = 0; id_ctr = 0; dsel = 0;
    for (int i = 0; i < 3; i++) last_rd[i] = '0;
    HRESET = 1'b1; HSEL = 1'b0; HTRANS = HTRANS_IDLE; HADDR = '0; HWDATA = '0;
    HWRITE = 1'b0; HSIZE = HSIZE_WORD; HBURST = '0; HPROT = '0;
    repeat (3) @(posedge HCLK);
    #1 HRESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cmp(i, "rst_hreadyout", {31'd0, ro[i]}, 32'd1);
      cmp(i, "rst_hresp", {31'd0, rs[i]}, 32'd0);
      cmp(i, "rst_hrdata", rd[i], 32'd0);
    end

    // zero-wait write then read
    addr_phase(1, 32'h10, HSIZE_WORD, HTRANS_NONSEQ, 32'hDEAD_BEEF, 0, 0); bus_idle();
    addr_phase(0, 32'h10, HSIZE_WORD, HTRANS_NONSEQ, 0, 32'hDEAD_BEEF, 0); bus_idle();
    // byte and halfword lanes
    addr_phase(1, 32'h20, HSIZE_WORD, HTRANS_NONSEQ, 32'h0000_0000, 0, 0);
    addr_phase(1, 32'h21, HSIZE_BYTE, HTRANS_NONSEQ, 32'h0000_1100, 0, 0);
    addr_phase(1, 32'h22, HSIZE_HALF, HTRANS_NONSEQ, 32'hAABB_0000, 0, 0); bus_idle();
    addr_phase(0, 32'h20, HSIZE_WORD, HTRANS_NONSEQ, 0, 32'hAABB_1100, 0); bus_idle();
    // error responses leave memory and HRDATA untouched
    addr_phase(1, 32'h0, HSIZE_WORD, HTRANS_NONSEQ, 32'hCAFE_F00D, 0, 0); bus_idle();
    addr_phase(1, 32'h400, HSIZE_WORD, HTRANS_NONSEQ, 32'h1111_1111, 0, 1); bus_idle();
    addr_phase(1, 32'h3, HSIZE_HALF, HTRANS_NONSEQ, 32'h2222_2222, 0, 1); bus_idle();
    addr_phase(1, 32'h0, 3'd3, HTRANS_NONSEQ, 32'h3333_3333, 0, 1); bus_idle();
    addr_phase(0, 32'h2, HSIZE_WORD, HTRANS_NONSEQ, 0, 0, 1); bus_idle();
    addr_phase(0, 32'h0, HSIZE_WORD, HTRANS_NONSEQ, 0, 32'hCAFE_F00D, 0); bus_idle();
    // pipelined write->read forwarding
    addr_phase(1, 32'h40, HSIZE_WORD, HTRANS_NONSEQ, 32'h1234_5678, 0, 0);
    addr_phase(0, 32'h40, HSIZE_WORD, HTRANS_NONSEQ, 0, 32'h1234_5678, 0); bus_idle();
    addr_phase(1, 32'h41, HSIZE_BYTE, HTRANS_NONSEQ, 32'h0000_9900, 0, 0);
    addr_phase(0, 32'h40, HSIZE_WORD, HTRANS_NONSEQ, 0, 32'h1234_9978, 0); bus_idle();
    addr_phase(1, 32'h44, HSIZE_WORD, HTRANS_NONSEQ, 32'h0BAD_F00D, 0, 0);
    addr_phase(0, 32'h40, HSIZE_WORD, HTRANS_NONSEQ, 0, 32'h1234_9978, 0); bus_idle();

    // two wait states: write burst, then 4-beat read burst
    dsel = 1;
    for (int i = 0; i < 4; i++)
      addr_phase(1, 32'h100 + 32'(4 * i), HSIZE_WORD, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ,
                 bdat[i], 0, 0);
    bus_idle();
    for (int i = 0; i < 4; i++)
      addr_phase(0, 32'h100 + 32'(4 * i), HSIZE_WORD, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ,
                 0, bdat[i], 0);
    bus_idle();

    // three wait states: reset during a write's wait state
    dsel = 2;
    addr_phase(1, 32'h50, HSIZE_WORD, HTRANS_NONSEQ, 32'h5A5A_5A5A, 0, 0); bus_idle();
    addr_phase(0, 32'h50, HSIZE_WORD, HTRANS_NONSEQ, 0, 32'h5A5A_5A5A, 0); bus_idle();
    addr_phase(1, 32'h50, HSIZE_WORD, HTRANS_NONSEQ, 32'hFFFF_0000, 0, 0);
    HSEL = 1'b0;
    HTRANS = HTRANS_IDLE;
    @(posedge HCLK);
    #1 HRESET = 1'b1;
    @(posedge HCLK);
    #1 HRESET = 1'b0;
    for (int i = 0; i < 3; i++) last_rd[i] = '0;
    cmp(100, "post_rst_hreadyout", {31'd0, bus_ready}, 32'd1);
    cmp(100, "post_rst_hresp", {31'd0, bus_resp}, 32'd0);
    cmp(100, "post_rst_hrdata", bus_rdata, 32'd0);
    addr_phase(0, 32'h50, HSIZE_WORD, HTRANS_NONSEQ, 0, 32'h5A5A_5A5A, 0); bus_idle();

    repeat (3) @(posedge HCLK);
    cmp(-1, "scoreboard_drain", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
